uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 29 ++
 rtl/uart_loader_rx.sv | 132 +++++++++++++
 rtl/uart_loader.sv | 157 +++++++++++++++
 tb/tb_uart_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_loader_pkg;

    // Protocol FSM states of the loader.
    typedef enum logic [2:0] {
        SYNC,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    // Serial receiver states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Byte that opens an image while hunting in SYNC.
    localparam logic [7:0] SYNC_BYTE = 8'h55;

    // Width of the little-endian word-count field.
    localparam int LEN_WIDTH = 16;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre-of-bit sampling, stop-bit check.
// Handshake: byte_valid and frame_err are single-cycle strobes with no
// back-pressure; byte_data is only meaningful in the byte_valid cycle and the
// consumer must take it then.
module uart_loader_rx
    import uart_loader_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    // Bit period rounded to the nearest whole clock.
    localparam int DIV  = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          fall;
    rx_state_t     state;
    rx_state_t     state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_clear;
    logic          start_ok;
    logic          sample_bit;
    logic          stop_done;

    assign fall      = rx_prev & ~rx_sync;
    assign byte_data = shreg;

    // Two-flop synchroniser plus one more stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and sample strobes; the start bit is re-checked half a period in.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        start_ok   = 1'b0;
        sample_bit = 1'b0;
        stop_done  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_clear = 1'b1;
                if (fall) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clear = 1'b1;
                    if (rx_sync) begin
                        state_next = RX_IDLE;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_clear  = 1'b1;
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_clear  = 1'b1;
                    stop_done  = 1'b1;
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Bit timer, LSB-first shift register and the registered result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cnt        <= cnt_clear ? '0 : cnt + CW'(1);
            byte_valid <= stop_done & rx_sync;
            frame_err  <= stop_done & ~rx_sync;
            if (start_ok) begin
                bit_idx <= '0;
            end
            if (sample_bit) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Serial boot loader: 55, length (LE, words), data (LE words), XOR checksum.
// Streams assembled words into main memory while holding the core in reset.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLOCK_RATE     = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int ADDR_WIDTH     = 14,
    parameter int MAX_WORDS      = 'h3800,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  busy,
    output logic                  error,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr
);

    localparam logic [LEN_WIDTH-1:0] MAX_N        = LEN_WIDTH'(MAX_WORDS);
    localparam logic [31:0]          TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 frame_err;
    state_t               state;
    state_t               state_next;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] len_full;
    logic [LEN_WIDTH-1:0] word_cnt;
    logic [1:0]           byte_cnt;
    logic [23:0]          wbuf;
    logic [7:0]           csum;
    logic [31:0]          tcnt;
    logic                 word_done;
    logic                 last_word;

    uart_loader_rx #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign mem_wmask = 4'hF;
    assign busy      = (state != DONE);
    assign error     = (state == ERROR);
    assign len_full  = {byte_data, len[7:0]};
    assign word_done = byte_valid && (byte_cnt == 2'd3);
    assign last_word = (word_cnt == len - 16'd1);

    // Protocol state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Protocol next state; a framing error anywhere but DONE is fatal.
    always_comb begin
        state_next = state;
        case (state)
            SYNC: begin
                if (byte_valid) begin
                    if (byte_data == SYNC_BYTE) begin
                        state_next = LEN0;
                    end
                end else if (tcnt == TIMEOUT_LAST) begin
                    state_next = DONE;
                end
            end
            LEN0: begin
                if (byte_valid) begin
                    state_next = LEN1;
                end
            end
            LEN1: begin
                if (byte_valid) begin
                    if (len_full > MAX_N) begin
                        state_next = ERROR;
                    end else if (len_full == '0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_done && last_word) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (byte_valid) begin
                    state_next = (byte_data == csum) ? DONE : ERROR;
                end
            end
            default: state_next = state;
        endcase
        if (frame_err && (state != DONE)) begin
            state_next = ERROR;
        end
    end

    // Timeout counter, length capture, word assembler, address counter, checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            wbuf      <= '0;
            csum      <= '0;
            tcnt      <= '0;
        end else begin
            mem_write <= 1'b0;
            if (state == SYNC) begin
                tcnt <= byte_valid ? '0 : tcnt + 32'd1;
            end
            if (byte_valid) begin
                case (state)
                    LEN0: len[7:0]  <= byte_data;
                    LEN1: len[15:8] <= byte_data;
                    DATA: begin
                        csum     <= csum ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: wbuf[7:0]   <= byte_data;
                            2'd1: wbuf[15:8]  <= byte_data;
                            2'd2: wbuf[23:16] <= byte_data;
                            default: begin
                                mem_wdata <= {byte_data, wbuf};
                                mem_addr  <= ADDR_WIDTH'(word_cnt);
                                mem_write <= 1'b1;
                                word_cnt  <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: table of images plus hand-written
// sequences for timeout, framing error, start glitch and mid-image reset.
module tb_uart_loader;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TMO    = 1000;
    localparam int AW     = 14;
    localparam int NVEC   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          busy;
    logic          error;
    logic          mem_write;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_addr;

    int n_total = 0;
    int n_pass  = 0;

    // Scoreboard: {addr, data} of each write the bench expects, in order.
    logic [AW+31:0] exp_q[$];
    logic           prev_wr = 1'b0;

    typedef struct packed {
        logic [4:0]       nbytes;
        logic [0:15][7:0] bytes;
        logic [1:0]       nwords;
        logic [0:1][31:0] words;
        logic             exp_busy;
        logic             exp_error;
    } vec_t;

    vec_t vecs [NVEC];

    uart_loader #(
        .CLOCK_RATE    (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .ADDR_WIDTH    (AW),
        .MAX_WORDS     ('h3800),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .busy     (busy),
        .error    (error),
        .mem_write(mem_write),
        .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata),
        .mem_addr (mem_addr)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard consumer: every write must be expected, single-cycle, full mask.
    always @(negedge clk) begin
        if (mem_write) begin
            check("write_pulse_width", {63'd0, prev_wr}, 64'd0);
            check("mem_wmask", {60'd0, mem_wmask}, 64'hF);
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("write_addr_data", {18'd0, mem_addr, mem_wdata}, {18'd0, exp_q.pop_front()});
            end
        end
        prev_wr = mem_write;
    end

    // One-cycle reset, then check the reset values of every output.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
    endtask

    // Drive one 8N1 frame; stop_bit=0 produces a framing error.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic exp_busy, input logic exp_error);
        check({tag, "_busy"}, {63'd0, busy}, {63'd0, exp_busy});
        check({tag, "_error"}, {63'd0, error}, {63'd0, exp_error});
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] cs;

        // 11^22^33^44^AA^BB^CC^DD = 44, so 44 is the correct checksum here.
        vecs[0] = '{nbytes: 5'd12,
                    bytes: {8'h55, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                            8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44, {4{8'h00}}},
                    nwords: 2'd2, words: {32'h44332211, 32'hDDCCBBAA},
                    exp_busy: 1'b0, exp_error: 1'b0};
        // Same image with checksum 66: both words are written, then ERROR.
        vecs[1] = '{nbytes: 5'd12,
                    bytes: {8'h55, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                            8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h66, {4{8'h00}}},
                    nwords: 2'd2, words: {32'h44332211, 32'hDDCCBBAA},
                    exp_busy: 1'b1, exp_error: 1'b1};
        // Leading junk, then an empty image.
        vecs[2] = '{nbytes: 5'd6,
                    bytes: {8'h00, 8'h7F, 8'h55, 8'h00, 8'h00, 8'h00, {10{8'h00}}},
                    nwords: 2'd0, words: '0,
                    exp_busy: 1'b0, exp_error: 1'b0};
        // One word, wrong checksum 05 (correct is 04).
        vecs[3] = '{nbytes: 5'd8,
                    bytes: {8'h55, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, {8{8'h00}}},
                    nwords: 2'd1, words: {32'h04030201, 32'h0},
                    exp_busy: 1'b1, exp_error: 1'b1};
        // N = 0x3801 is one above the largest accepted length.
        vecs[4] = '{nbytes: 5'd3,
                    bytes: {8'h55, 8'h01, 8'h38, {13{8'h00}}},
                    nwords: 2'd0, words: '0,
                    exp_busy: 1'b1, exp_error: 1'b1};
        // Random two-word image with its checksum computed here.
        vecs[5] = '0;
        vecs[5].nbytes   = 5'd12;
        vecs[5].nwords   = 2'd2;
        vecs[5].bytes[0] = 8'h55;
        vecs[5].bytes[1] = 8'h02;
        vecs[5].bytes[2] = 8'h00;
        cs = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            vecs[5].bytes[3 + i] = b;
            vecs[5].words[i / 4][8 * (i % 4) +: 8] = b;
            cs = cs ^ b;
        end
        vecs[5].bytes[11] = cs;

        // Table-driven images.
        for (int v = 0; v < NVEC; v++) begin
            do_reset();
            for (int w = 0; w < int'(vecs[v].nwords); w++) begin
                exp_q.push_back({AW'(w), vecs[v].words[w]});
            end
            for (int i = 0; i < int'(vecs[v].nbytes); i++) begin
                send_byte(vecs[v].bytes[i], 1'b1);
            end
            idle(2 * DIV);
            check_flags($sformatf("vec%0d", v), vecs[v].exp_busy, vecs[v].exp_error);
            check_drained($sformatf("vec%0d", v));
        end

        // N equal to the limit is accepted: still loading, no error.
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h38, 1'b1);
        idle(2 * DIV);
        check_flags("max_len", 1'b1, 1'b0);
        check_drained("max_len");

        // Idle timeout: busy drops on exactly the TMO-th cycle after reset.
        do_reset();
        idle(TMO - 1);
        check_flags("timeout_before", 1'b1, 1'b0);
        idle(1);
        check_flags("timeout_at", 1'b0, 1'b0);
        // A full image in DONE must change nothing and write nothing.
        for (int i = 0; i < 8; i++) begin
            send_byte(vecs[3].bytes[i], 1'b1);
        end
        idle(2 * DIV);
        check_flags("done_inert", 1'b0, 1'b0);
        check_drained("done_inert");

        // Low stop bit in the middle of a word.
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        idle(2 * DIV);
        check_flags("frame_err", 1'b1, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(2 * DIV);
        check_flags("error_inert", 1'b1, 1'b1);
        check_drained("frame_err");

        // Reset after the second word of a three-word image, then a full re-send.
        do_reset();
        exp_q.push_back({AW'(0), 32'h04030201});
        exp_q.push_back({AW'(1), 32'h08070605});
        send_byte(8'h55, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b1);
        end
        idle(2);
        check_drained("abort_writes");
        do_reset();
        // Short low glitch: start bit re-check rejects it.
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(3 * DIV);
        check_flags("glitch", 1'b1, 1'b0);
        exp_q.push_back({AW'(0), 32'h44332211});
        exp_q.push_back({AW'(1), 32'hDDCCBBAA});
        for (int i = 0; i < 12; i++) begin
            send_byte(vecs[0].bytes[i], 1'b1);
        end
        idle(2 * DIV);
        check_flags("resend", 1'b0, 1'b0);
        check_drained("resend");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
